// File: rtl/sqwave_pkg.sv
// Shared types and defaults for the multi-channel square-wave generator.
// Optional phase sync is enabled by SQWAVE_PHASE_SYNC_EN in the channel and top files.
package sqwave_pkg;

    localparam int unsigned SQW_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } phase_t;

    // First phase of a period: high if there is any high time, else low, else park.
    function automatic phase_t entry_phase(input logic hi_nz, input logic lo_nz);
        if (hi_nz) return HIGH;
        if (lo_nz) return LOW;
        return IDLE;
    endfunction

endpackage

// File: rtl/sqwave_chan.sv
// One square-wave channel: high/low counter with counts double-buffered to the period boundary.
// SQWAVE_PHASE_SYNC_EN adds a sync input that forces a boundary on the next edge.
module sqwave_chan
    import sqwave_pkg::*;
#(
    parameter int unsigned W = SQW_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] rise,
    input  logic [W-1:0] fall,
`ifdef SQWAVE_PHASE_SYNC_EN
    input  logic         sync,
`endif
    output logic         clk_out,
    output logic         period_done
);

    phase_t       st;
    logic [W-1:0] cnt;
    logic [W-1:0] act_hi;
    logic [W-1:0] act_lo;
    logic [W-1:0] pend_hi;
    logic [W-1:0] pend_lo;
    logic         pend_v;

    logic [W-1:0] nxt_hi_c;
    logic [W-1:0] nxt_lo_c;
    logic         nxt_hi_nz_c;
    logic         nxt_lo_nz_c;
    logic         hi_last_c;
    logic         lo_last_c;
    logic         sync_hit_c;
    logic         boundary_c;

    // Counts that take effect at the next period start (pending wins if present).
    assign nxt_hi_c    = pend_v ? pend_hi : act_hi;
    assign nxt_lo_c    = pend_v ? pend_lo : act_lo;
    assign nxt_hi_nz_c = |nxt_hi_c;
    assign nxt_lo_nz_c = |nxt_lo_c;
    assign hi_last_c   = (cnt == W'(act_hi - W'(1)));
    assign lo_last_c   = (cnt == W'(act_lo - W'(1)));

`ifdef SQWAVE_PHASE_SYNC_EN
    assign sync_hit_c = sync & en;
`else
    assign sync_hit_c = 1'b0;
`endif

    assign boundary_c = sync_hit_c
                      | ((st == HIGH) && hi_last_c && (act_lo == '0))
                      | ((st == LOW) && lo_last_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            cnt         <= '0;
            act_hi      <= '0;
            act_lo      <= '0;
            pend_hi     <= '0;
            pend_lo     <= '0;
            pend_v      <= 1'b0;
            clk_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (!en) begin
                st      <= IDLE;
                cnt     <= '0;
                clk_out <= 1'b0;
                act_hi  <= nxt_hi_c;
                act_lo  <= nxt_lo_c;
                pend_v  <= 1'b0;
            end else if ((st == IDLE) || boundary_c) begin
                // Period start: promote pending counts and pick the first phase.
                act_hi      <= nxt_hi_c;
                act_lo      <= nxt_lo_c;
                pend_v      <= 1'b0;
                cnt         <= '0;
                st          <= entry_phase(nxt_hi_nz_c, nxt_lo_nz_c);
                clk_out     <= nxt_hi_nz_c;
                period_done <= boundary_c && (nxt_hi_nz_c || nxt_lo_nz_c);
            end else if ((st == HIGH) && hi_last_c) begin
                st      <= LOW;
                cnt     <= '0;
                clk_out <= 1'b0;
            end else begin
                cnt <= cnt + W'(1);
            end

            // Loads land after the boundary logic so a load in a boundary cycle stays pending.
            if (load) begin
                if (st == IDLE) begin
                    act_hi <= rise;
                    act_lo <= fall;
                end else begin
                    pend_hi <= rise;
                    pend_lo <= fall;
                    pend_v  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sqwave_gen_multi.sv
// Multi-channel square-wave generator: slices packed counts and replicates sqwave_chan.
// SQWAVE_PHASE_SYNC_EN adds the shared sync input used to phase-align all channels.
module sqwave_gen_multi
    import sqwave_pkg::*;
#(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = SQW_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] rise,
    input  logic [CH*W-1:0] fall,
`ifdef SQWAVE_PHASE_SYNC_EN
    input  logic            sync,
`endif
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   period_done
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        sqwave_chan #(
            .W(W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en[i]),
            .load       (load[i]),
            .rise       (rise[i*W +: W]),
            .fall       (fall[i*W +: W]),
`ifdef SQWAVE_PHASE_SYNC_EN
            .sync       (sync),
`endif
            .clk_out    (clk_out[i]),
            .period_done(period_done[i])
        );
    end

endmodule

// File: tb/tb_sqwave_gen_multi.sv
// Directed self-checking bench for sqwave_gen_multi (CH=4, W=8).
// Exercises the SQWAVE_PHASE_SYNC_EN sync path only when that macro is defined.
module tb_sqwave_gen_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] rise;
    logic [CH*W-1:0] fall;
    logic            sync;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   period_done;

    int checks   = 0;
    int failures = 0;

    sqwave_gen_multi #(
        .CH(CH),
        .W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .rise       (rise),
        .fall       (fall),
`ifdef SQWAVE_PHASE_SYNC_EN
        .sync       (sync),
`endif
        .clk_out    (clk_out),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_counts(input int ch, input int hi, input int lo);
        rise[ch*W +: W] = W'(hi);
        fall[ch*W +: W] = W'(lo);
    endtask

    initial begin
        int hi_t [CH];
        int lo_t [CH];
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_pd;

        hi_t = '{2, 3, 1, 5};
        lo_t = '{2, 1, 1, 3};
        rst  = 1'b1;
        en   = '0;
        load = '0;
        rise = '0;
        fall = '0;
        sync = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_clk_out", 32'(clk_out), 32'h0);
        chk("reset_pd", 32'(period_done), 32'h0);
        rst = 1'b0;

        // 3/2 from IDLE, switch to 1/4 mid-HIGH, then a load in a boundary cycle (0/5)
        set_counts(0, 3, 2);
        load[0] = 1'b1;
        step();
        load[0] = 1'b0;
        chk("idle_after_load", 32'(clk_out[0]), 32'h0);
        en[0] = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            int hi;
            int lo;
            int base;
            int p;
            if (n == 18) begin
                set_counts(0, 1, 4);
                load[0] = 1'b1;
            end
            if (n == 31) begin
                set_counts(0, 0, 5);
                load[0] = 1'b1;
            end
            step();
            load[0] = 1'b0;
            if (n <= 20) begin
                hi = 3; lo = 2; base = 1;
            end else if (n <= 35) begin
                hi = 1; lo = 4; base = 21;
            end else begin
                hi = 0; lo = 5; base = 36;
            end
            p = (n - base) % (hi + lo);
            chk($sformatf("seq_clk n=%0d", n), 32'(clk_out[0]), 32'(p < hi));
            chk($sformatf("seq_pd n=%0d", n), 32'(period_done[0]), 32'((n > 1) && (p == 0)));
            if (n == 5) chk("others_idle", 32'(clk_out[3:1]), 32'h0);
        end

        // 4/0: always high, pulse every 4; then a 0/0 load parks the channel in IDLE
        en[0] = 1'b0;
        step();
        chk("disable_clk_out", 32'(clk_out[0]), 32'h0);
        set_counts(0, 4, 0);
        load[0] = 1'b1;
        step();
        load[0] = 1'b0;
        en[0] = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            int p;
            if (n == 13) begin
                set_counts(0, 0, 0);
                load[0] = 1'b1;
            end
            step();
            load[0] = 1'b0;
            p = (n - 1) % 4;
            if (n <= 16) begin
                chk($sformatf("hi_only_clk n=%0d", n), 32'(clk_out[0]), 32'h1);
                chk($sformatf("hi_only_pd n=%0d", n), 32'(period_done[0]), 32'((n > 1) && (p == 0)));
            end else begin
                chk($sformatf("zero_clk n=%0d", n), 32'(clk_out[0]), 32'h0);
                chk($sformatf("zero_pd n=%0d", n), 32'(period_done[0]), 32'h0);
            end
        end

        // Restart from IDLE by loading nonzero counts with en held high
        set_counts(0, 2, 3);
        load[0] = 1'b1;
        step();
        load[0] = 1'b0;
        chk("restart_load_cycle", 32'(clk_out[0]), 32'h0);
        for (int n = 1; n <= 8; n++) begin
            int p;
            step();
            p = (n - 1) % 5;
            chk($sformatf("restart_clk n=%0d", n), 32'(clk_out[0]), 32'(p < 2));
            chk($sformatf("restart_pd n=%0d", n), 32'(period_done[0]), 32'((n > 1) && (p == 0)));
        end

        // Reset mid-LOW with en high: output drops and channel stays parked
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_low_clk", 32'(clk_out[0]), 32'h0);
        chk("rst_mid_low_pd", 32'(period_done[0]), 32'h0);
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("post_rst_idle n=%0d", n), 32'({period_done[0], clk_out[0]}), 32'h0);
        end

        // All four channels with independent counts, enabled together
        en = '0;
        step();
        for (int c = 0; c < int'(CH); c++) set_counts(c, hi_t[c], lo_t[c]);
        load = '1;
        step();
        load = '0;
        en = '1;
        for (int n = 1; n <= 100; n++) begin
            step();
            for (int c = 0; c < int'(CH); c++) begin
                int p;
                p = (n - 1) % (hi_t[c] + lo_t[c]);
                exp_clk[c] = (p < hi_t[c]);
                exp_pd[c]  = (n > 1) && (p == 0);
            end
            chk($sformatf("multi_clk n=%0d", n), 32'(clk_out), 32'(exp_clk));
            chk($sformatf("multi_pd n=%0d", n), 32'(period_done), 32'(exp_pd));
        end

`ifdef SQWAVE_PHASE_SYNC_EN
        // Sync forces every enabled channel to a fresh period on the same edge
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_clk", 32'(clk_out), 32'hF);
        chk("sync_pd", 32'(period_done), 32'hF);
        step();
        chk("sync_next_clk", 32'(clk_out), 32'b1011);
        chk("sync_next_pd", 32'(period_done), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqwave_gen_multi.md
# sqwave_gen_multi

Multi-channel programmable square-wave generator, the parametrised successor to the single-channel high/low-count generator. Each of `CH` channels produces an independent waveform whose high and low durations, in `clk` cycles, come from per-channel counts of width `W`. New counts are double-buffered and applied only at a period boundary, so waveforms never glitch. The block sits in the clock/timing area and drives blink, tick and strobe outputs for the display and clock logic.

## Interface
- `CH`, default 4: number of independent channels.
- `W`, default 8: count width; high/low durations range 0..2^W-1 cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  CH  per-channel run enable.
- `load`  in  CH  per-channel strobe; captures that channel's `rise`/`fall` slice.
- `rise`  in  CH*W  high-phase cycle counts; channel i at bits [i*W +: W].
- `fall`  in  CH*W  low-phase cycle counts; same packing.
- `clk_out`  out  CH  registered waveform outputs.
- `period_done`  out  CH  one-cycle pulse on the first cycle of each new period.
- `sync`  in  1  present only with `SQWAVE_PHASE_SYNC_EN`.

## Operation
- Per-channel state: `IDLE`, `HIGH`, `LOW`. Registers: `cnt[W]`, active `act_hi`/`act_lo`, pending `pend_hi`/`pend_lo`, `pend_v`.
- Reset: state `IDLE`, `cnt`=0, `act_*`=0, `pend_*`=0, `pend_v`=0, `clk_out`=0, `period_done`=0.
- `load` in `IDLE`: writes `act_*` directly. `load` in `HIGH`/`LOW`: writes `pend_*` and sets `pend_v`. A second load before the boundary overwrites the pending values (last wins).
- `IDLE` with `en`=1: the next state is `HIGH` if `act_hi`≠0, `LOW` if `act_hi`=0 and `act_lo`≠0, and stays `IDLE` if both are 0. `cnt` is set to 0.
- `HIGH`: `clk_out`=1. When `cnt`==`act_hi`-1, go to `LOW` and set `cnt`=0. If `act_lo`=0, this is instead a boundary (see below). Otherwise `cnt`++.
- `LOW`: `clk_out`=0. When `cnt`==`act_lo`-1, this is a boundary. Otherwise `cnt`++.
- Boundary: if `pend_v`, copy `pend_*` into `act_*` and clear `pend_v`. The next state follows the `IDLE` entry rule using the new `act_*` values. `cnt`=0. `period_done` is registered high for the first cycle of the new period.
- Both counts 0 while running: return to `IDLE` with `clk_out`=0 and no `period_done`. The channel restarts automatically once a load gives nonzero counts; the pending values are promoted in `IDLE`.
- `en` deasserted: the next cycle is `IDLE`, `clk_out`=0, `cnt`=0. A pending load is promoted into `act_*`.
- `rst` overrides `en`, `load` and `sync` in every state. Reset mid-period truncates the waveform immediately.

## Timing
- `en` sampled high at edge k: `clk_out` is valid from edge k+1, and the first cycle is not flagged by `period_done`.
- Period is exactly `act_hi`+`act_lo` cycles, with duty `act_hi`/(`act_hi`+`act_lo`).
- A load at cycle t while running takes effect at the first boundary after t. A load in the boundary cycle itself applies at the following boundary.
- `period_done` is aligned with the first `clk_out` cycle of the new period.
- Channels are fully independent; there is no cross-channel arbitration.

## Configuration
- `SQWAVE_PHASE_SYNC_EN` defined: adds the `sync` port. `sync`=1 forces every enabled channel to a boundary on the next edge: pending values are promoted, `cnt`=0, the HIGH-first rule applies, and `period_done` pulses. This phase-aligns all channels. `sync` has priority over per-channel count completion, and disabled channels ignore it.
- Macro undefined: no `sync` port and no sync logic. Channels align only through simultaneous `en`.

## Structure
- `sqwave_pkg` holds the phase enum (`IDLE`, `HIGH`, `LOW`) and the default width constant `SQW_W_DEF`.
- Sub-module `sqwave_chan` implements one channel and is instantiated `CH` times in a generate loop. The top level only slices `rise`/`fall` and fans out `sync`.

## Test plan
- Ch0 `rise`=3, `fall`=2, `load`, then `en`: `clk_out` pattern 1,1,1,0,0 repeating, with `period_done` every 5 cycles starting at cycle 6.
- While running 3/2, load 1/4 mid-HIGH: the current period finishes as 3/2, then 1,0,0,0,0 follows, and `period_done` marks the switch.
- `rise`=0, `fall`=5: `clk_out` stays 0 and `period_done` pulses every 5 cycles. With `rise`=4, `fall`=0: `clk_out` stays 1 and pulses every 4 cycles. With both 0: output 0 and no pulses.
- `rst` asserted mid-LOW with `en` still high: the next cycle has `clk_out`=0 and `act_*`=0, and the channel stays `IDLE` until reloaded.
- Channels 0..3 loaded 2/2, 3/1, 1/1, 5/3 and enabled together: each period is verified independently over 100 cycles.
- With `SQWAVE_PHASE_SYNC_EN`: channels run out of phase, `sync` is pulsed, and all enabled `clk_out` go high on the same edge with `period_done` asserted on every channel.
